int_datapath_md: RTL and testbench

- Parametrised next-generation integer datapath containing:
  - a 2^AW x DW register file;
  - registered operand stage;
  - built-in single-cycle ALU;
  - iterative multi-cycle multiply/divide unit writing HI/LO, with a busy/done handshake.
- Sits between the control unit (FS, selects, enables) and memory/IO (DT, DY, IO_IN, D_OUT).
- Replaces the fixed-32-bit, combinational-HILO datapath in the MIPS core.

---
 rtl/int_datapath_md.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_int_datapath_md.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_datapath_md.sv
// Integer datapath: register file, registered operands, single-cycle ALU and an iterative
// mul/div unit writing HI/LO. Define DP_BYPASS_EN to forward same-cycle writes into operands.
module int_datapath_md #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned SP_ADDR = 29,
  parameter int unsigned RA_ADDR = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_en,
  input  logic [1:0]    da_sel,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] s_addr,
  input  logic [AW-1:0] t_addr,
  input  logic          s_sel,
  input  logic          t_sel,
  input  logic [DW-1:0] dt,
  input  logic [4:0]    shamt,
  input  logic [4:0]    fs,
  input  logic          md_start,
  input  logic [1:0]    md_op,
  input  logic [1:0]    hilo_wr,
  input  logic [DW-1:0] dy,
  input  logic [DW-1:0] io_in,
  input  logic          din_sel,
  input  logic [DW-1:0] pc_in,
  input  logic [2:0]    y_sel,
  input  logic [3:0]    flags_in,
  input  logic [1:0]    d_out_sel,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] d_out,
  output logic          c,
  output logic          v,
  output logic          n,
  output logic          z,
  output logic          md_busy,
  output logic          md_done,
  output logic          md_dz
);

  localparam int unsigned NReg = 1 << AW;
  localparam int unsigned CntW = $clog2(DW) + 1;
  localparam logic [AW-1:0] SpAddr = AW'(SP_ADDR);
  localparam logic [AW-1:0] RaAddr = AW'(RA_ADDR);

  typedef enum logic [1:0] {StIdle, StRun, StFix} md_state_e;

  logic [DW-1:0] rf_q [NReg];
  logic [DW-1:0] rs_q, rt_q, alu_q, din_q, pc_q, hi_q, lo_q;
  logic [4:0]    sh_q;

  // Register file
  logic [AW-1:0] wa, s_ra;
  logic [DW-1:0] s_rf, t_rf, s_op, t_op;

  always_comb begin
    case (da_sel)
      2'b00:   wa = d_addr;
      2'b01:   wa = t_addr;
      2'b10:   wa = RaAddr;
      default: wa = SpAddr;
    endcase
    s_ra = s_sel ? SpAddr : s_addr;
    s_rf = (s_ra == '0) ? '0 : rf_q[s_ra];
    t_rf = (t_addr == '0) ? '0 : rf_q[t_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NReg; i++) rf_q[i] <= '0;
    end else if (d_en && (wa != '0)) begin
      rf_q[wa] <= y_out;
    end
  end

  // Operand capture
`ifdef DP_BYPASS_EN
  always_comb begin
    s_op = (d_en && (wa != '0) && (wa == s_ra)) ? y_out : s_rf;
    t_op = (d_en && !t_sel && (wa != '0) && (wa == t_addr)) ? y_out : t_rf;
  end
`else
  always_comb begin
    s_op = s_rf;
    t_op = t_rf;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_q  <= '0;
      rt_q  <= '0;
      sh_q  <= '0;
      din_q <= '0;
      pc_q  <= '0;
    end else begin
      rs_q  <= s_op;
      rt_q  <= t_sel ? dt : t_op;
      sh_q  <= shamt;
      din_q <= din_sel ? io_in : dy;
      pc_q  <= pc_in;
    end
  end

  // ALU: one shared adder; subtract-class ops feed ~T with carry-in 1
  logic [DW-1:0] add_b, add_s, alu_res;
  logic          add_cin, add_co, add_v;
  logic          alu_c, alu_v, alu_ok;
  int unsigned   sh_amt;

  always_comb begin
    add_b   = rt_q;
    add_cin = 1'b0;
    case (fs)
      5'h04, 5'h05, 5'h06, 5'h07: begin
        add_b   = ~rt_q;
        add_cin = 1'b1;
      end
      5'h0F: begin
        add_b   = '0;
        add_cin = 1'b1;
      end
      5'h10: begin
        add_b   = '1;
        add_cin = 1'b0;
      end
      default: ;
    endcase
    {add_co, add_s} = {1'b0, rs_q} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
    add_v = (rs_q[DW-1] == add_b[DW-1]) && (add_s[DW-1] != rs_q[DW-1]);
  end

  always_comb begin
    sh_amt  = 32'(sh_q) % DW;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ok  = 1'b1;
    case (fs)
      5'h00: alu_res = rs_q;
      5'h01: alu_res = rt_q;
      5'h02, 5'h04, 5'h0F, 5'h10: begin
        alu_res = add_s;
        alu_c   = add_co;
        alu_v   = add_v;
      end
      5'h03, 5'h05: begin
        alu_res = add_s;
        alu_c   = add_co;
      end
      5'h06: begin
        alu_res = DW'($signed(rs_q) < $signed(rt_q));
        alu_c   = add_co;
      end
      5'h07: begin
        alu_res = DW'(rs_q < rt_q);
        alu_c   = add_co;
      end
      5'h08: alu_res = rs_q & rt_q;
      5'h09: alu_res = rs_q | rt_q;
      5'h0A: alu_res = rs_q ^ rt_q;
      5'h0B: alu_res = ~(rs_q | rt_q);
      5'h0C: alu_res = rt_q << sh_amt;
      5'h0D: alu_res = rt_q >> sh_amt;
      5'h0E: alu_res = $signed(rt_q) >>> sh_amt;
      default: alu_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_q <= '0;
      c     <= 1'b0;
      v     <= 1'b0;
      n     <= 1'b0;
      z     <= 1'b0;
    end else begin
      alu_q <= alu_res;
      c     <= alu_c;
      v     <= alu_v;
      n     <= alu_ok & alu_res[DW-1];
      z     <= alu_ok & (alu_res == '0);
    end
  end

  // Mul/div unit: md_p_q is {hi, lo}; multiply shifts right, divide shifts left
  md_state_e       md_state_q;
  logic [1:0]      md_op_q;
  logic [CntW-1:0] md_cnt_q;
  logic [2*DW-1:0] md_p_q;
  logic [DW-1:0]   md_m_q, md_a_q;
  logic            md_na_q, md_nb_q;

  logic            st_sgn, st_na, st_nb;
  logic [DW-1:0]   st_ma, st_mb;
  logic [DW:0]     mul_sum, div_sh, div_diff;
  logic [2*DW-1:0] mul_next, div_next, f_prod;
  logic            f_sgn, f_dz;
  logic [DW-1:0]   f_q, f_r, fix_hi, fix_lo;

  always_comb begin
    st_sgn = !md_op[0];
    st_na  = st_sgn & rs_q[DW-1];
    st_nb  = st_sgn & rt_q[DW-1];
    st_ma  = st_na ? (~rs_q + 1'b1) : rs_q;
    st_mb  = st_nb ? (~rt_q + 1'b1) : rt_q;

    mul_sum  = {1'b0, md_p_q[2*DW-1:DW]} + {1'b0, (md_p_q[0] ? md_m_q : {DW{1'b0}})};
    mul_next = {mul_sum, md_p_q[DW-1:1]};

    div_sh   = {md_p_q[2*DW-1:DW], md_p_q[DW-1]};
    div_diff = div_sh - {1'b0, md_m_q};
    div_next = !div_diff[DW] ? {div_diff[DW-1:0], md_p_q[DW-2:0], 1'b1}
                             : {div_sh[DW-1:0], md_p_q[DW-2:0], 1'b0};

    f_sgn  = !md_op_q[0];
    f_dz   = md_op_q[1] && (md_m_q == '0);
    f_prod = (f_sgn && (md_na_q ^ md_nb_q)) ? (~md_p_q + 1'b1) : md_p_q;
    f_q    = (f_sgn && (md_na_q ^ md_nb_q)) ? (~md_p_q[DW-1:0] + 1'b1) : md_p_q[DW-1:0];
    f_r    = (f_sgn && md_na_q) ? (~md_p_q[2*DW-1:DW] + 1'b1) : md_p_q[2*DW-1:DW];

    if (!md_op_q[1]) begin
      fix_hi = f_prod[2*DW-1:DW];
      fix_lo = f_prod[DW-1:0];
    end else if (f_dz) begin
      fix_hi = md_a_q;
      fix_lo = '1;
    end else begin
      fix_hi = f_r;
      fix_lo = f_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_state_q <= StIdle;
      md_op_q    <= '0;
      md_cnt_q   <= '0;
      md_p_q     <= '0;
      md_m_q     <= '0;
      md_a_q     <= '0;
      md_na_q    <= 1'b0;
      md_nb_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      md_busy    <= 1'b0;
      md_done    <= 1'b0;
      md_dz      <= 1'b0;
    end else begin
      md_done <= 1'b0;
      if (!md_busy && hilo_wr[1]) hi_q <= rs_q;
      if (!md_busy && hilo_wr[0]) lo_q <= rs_q;
      case (md_state_q)
        StIdle: begin
          if (md_start) begin
            md_op_q    <= md_op;
            md_cnt_q   <= '0;
            md_p_q     <= {{DW{1'b0}}, st_ma};
            md_m_q     <= st_mb;
            md_a_q     <= rs_q;
            md_na_q    <= st_na;
            md_nb_q    <= st_nb;
            md_busy    <= 1'b1;
            md_dz      <= 1'b0;
            md_state_q <= StRun;
          end
        end
        StRun: begin
          md_p_q <= md_op_q[1] ? div_next : mul_next;
          if (md_cnt_q == CntW'(DW - 1)) md_state_q <= StFix;
          else md_cnt_q <= md_cnt_q + 1'b1;
        end
        StFix: begin
          hi_q       <= fix_hi;
          lo_q       <= fix_lo;
          md_done    <= 1'b1;
          md_busy    <= 1'b0;
          if (f_dz) md_dz <= 1'b1;
          md_state_q <= StIdle;
        end
        default: md_state_q <= StIdle;
      endcase
    end
  end

  // Writeback and data-out muxes
  always_comb begin
    case (y_sel)
      3'b000:  y_out = hi_q;
      3'b001:  y_out = lo_q;
      3'b010:  y_out = alu_q;
      3'b011:  y_out = din_q;
      3'b100:  y_out = pc_q;
      default: y_out = '0;
    endcase
    case (d_out_sel)
      2'b01:   d_out = pc_q;
      2'b10:   d_out = {{(DW-4){1'b0}}, flags_in};
      default: d_out = rt_q;
    endcase
  end

endmodule

// File: tb/tb_int_datapath_md.sv
// Scoreboard bench for int_datapath_md: stimulus queues timestamped expectations, a negedge
// monitor compares them and checks md_done timing against the start edge.
module tb_int_datapath_md;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_en, s_sel, t_sel, md_start, din_sel;
  logic [1:0]  da_sel, md_op, hilo_wr, d_out_sel;
  logic [4:0]  d_addr, s_addr, t_addr, shamt, fs;
  logic [31:0] dt, dy, io_in, pc_in;
  logic [2:0]  y_sel;
  logic [3:0]  flags_in;
  logic [31:0] y_out, d_out;
  logic        c, v, n, z, md_busy, md_done, md_dz;

  int_datapath_md dut (
    .clk(clk), .reset(reset), .d_en(d_en), .da_sel(da_sel), .d_addr(d_addr),
    .s_addr(s_addr), .t_addr(t_addr), .s_sel(s_sel), .t_sel(t_sel), .dt(dt),
    .shamt(shamt), .fs(fs), .md_start(md_start), .md_op(md_op), .hilo_wr(hilo_wr),
    .dy(dy), .io_in(io_in), .din_sel(din_sel), .pc_in(pc_in), .y_sel(y_sel),
    .flags_in(flags_in), .d_out_sel(d_out_sel), .y_out(y_out), .d_out(d_out),
    .c(c), .v(v), .n(n), .z(z), .md_busy(md_busy), .md_done(md_done), .md_dz(md_dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          kind;  // 0 y_out, 1 d_out, 2 {c,v,n,z}, 3 md_busy, 4 md_dz
    logic [31:0] exp;
    int          due;
  } chk_t;

  chk_t        exp_q[$];
  int          md_q[$];
  int          errors = 0;
  int          checks = 0;
  chk_t        mon_e;
  logic [31:0] mon_act;
  int          mon_c;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      case (mon_e.kind)
        0:       mon_act = y_out;
        1:       mon_act = d_out;
        2:       mon_act = {28'h0, c, v, n, z};
        3:       mon_act = {31'h0, md_busy};
        default: mon_act = {31'h0, md_dz};
      endcase
      checks++;
      if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
      end
    end
    if (md_done === 1'b1) begin
      checks++;
      if (md_q.size() == 0) begin
        errors++;
        $display("FAIL md_done_spurious: got done at cycle %0d expected none", cyc);
      end else begin
        mon_c = md_q.pop_front();
        if (cyc != mon_c) begin
          errors++;
          $display("FAIL md_done_timing: got cycle %0d expected %0d", cyc, mon_c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] e);
    exp_q.push_back('{name: nm, kind: k, exp: e, due: cyc});
  endtask

  task automatic wreg(input logic [4:0] a, input logic [31:0] val);
    dy = val; din_sel = 1'b0; d_en = 1'b0; tick();
    d_en = 1'b1; da_sel = 2'b00; d_addr = a; y_sel = 3'd3; tick();
    d_en = 1'b0;
  endtask

  task automatic alu(input logic [4:0] s, input logic [4:0] t, input logic [4:0] f,
                     input logic [4:0] sh);
    s_sel = 1'b0; t_sel = 1'b0; s_addr = s; t_addr = t; fs = f; shamt = sh;
    tick(); tick();
    y_sel = 3'd2;
  endtask

  task automatic md_go(input logic [4:0] s, input logic [4:0] t, input logic [1:0] op);
    s_sel = 1'b0; t_sel = 1'b0; s_addr = s; t_addr = t; tick();
    md_op = op; md_start = 1'b1; tick();
    md_start = 1'b0;
    md_q.push_back(cyc + 33);
    chk("md_busy_start", 3, 32'h1);
  endtask

  task automatic md_wait();
    for (int i = 0; i < 40; i++) begin
      if (md_busy === 1'b0) break;
      tick();
    end
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL md_timeout: got busy %b expected 0", md_busy);
    end
  endtask

  task automatic hilo_chk(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    y_sel = 3'd0; chk({nm, "_hi"}, 0, hi); tick();
    y_sel = 3'd1; chk({nm, "_lo"}, 0, lo); tick();
  endtask

  logic [31:0] byp_exp;

  initial begin
    reset = 1'b0; d_en = 0; da_sel = 0; d_addr = 0; s_addr = 0; t_addr = 0; s_sel = 0;
    t_sel = 0; dt = 0; shamt = 0; fs = 0; md_start = 0; md_op = 0; hilo_wr = 0; dy = 0;
    io_in = 0; din_sel = 0; pc_in = 0; y_sel = 0; flags_in = 0; d_out_sel = 0;
    tick(); tick();
    chk("rst_hi", 0, 32'h0); chk("rst_flags", 2, 32'h0); chk("rst_busy", 3, 32'h0);
    chk("rst_dz", 4, 32'h0); chk("rst_dout", 1, 32'h0);
    tick();
    reset = 1'b1; tick();

    // ADD overflow, writeback, readback
    wreg(5'd1, 32'h7FFF_FFFF); wreg(5'd2, 32'h1);
    alu(5'd1, 5'd2, 5'h02, 5'd0);
    chk("add_y", 0, 32'h8000_0000); chk("add_flags", 2, 32'b0110);
    d_en = 1'b1; da_sel = 2'b00; d_addr = 5'd3; y_sel = 3'd2; tick(); d_en = 1'b0;
    alu(5'd3, 5'd0, 5'h00, 5'd0);
    chk("r3_read", 0, 32'h8000_0000); chk("r3_flags", 2, 32'b0010);

    wreg(5'd5, 32'd5); wreg(5'd6, 32'd5);
    alu(5'd5, 5'd6, 5'h04, 5'd0);
    chk("sub_y", 0, 32'h0); chk("sub_flags", 2, 32'b1001);

    alu(5'd3, 5'd3, 5'h0E, 5'(36));
    chk("sra_y", 0, 32'hF800_0000); chk("sra_flags", 2, 32'b0010);
    alu(5'd1, 5'd1, 5'h0C, 5'd4);  chk("sll_y", 0, 32'hFFFF_FFF0);
    alu(5'd3, 5'd3, 5'h0D, 5'd31); chk("srl_y", 0, 32'h1);
    alu(5'd3, 5'd1, 5'h06, 5'd0);  chk("slt_y", 0, 32'h1);
    alu(5'd3, 5'd1, 5'h07, 5'd0);  chk("sltu_y", 0, 32'h0);
    alu(5'd1, 5'd0, 5'h0F, 5'd0);
    chk("inc_y", 0, 32'h8000_0000); chk("inc_flags", 2, 32'b0110);
    alu(5'd0, 5'd0, 5'h10, 5'd0);
    chk("dec_y", 0, 32'hFFFF_FFFF); chk("dec_flags", 2, 32'b0010);
    alu(5'd0, 5'd0, 5'h0B, 5'd0);  chk("nor_y", 0, 32'hFFFF_FFFF);
    alu(5'd1, 5'd2, 5'h1F, 5'd0);
    chk("undef_y", 0, 32'h0); chk("undef_flags", 2, 32'b0000);

    // MULT with an ignored retrigger while busy
    wreg(5'd7, 32'hFFFF_FFFD); wreg(5'd8, 32'd7);
    md_go(5'd7, 5'd8, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    md_op = 2'b10; md_start = 1'b1; tick(); md_start = 1'b0;
    md_wait();
    hilo_chk("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    wreg(5'd7, 32'hFFFF_FFF9); wreg(5'd8, 32'd2);
    md_go(5'd7, 5'd8, 2'b10); md_wait();
    hilo_chk("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    wreg(5'd7, 32'h8000_0000); wreg(5'd8, 32'hFFFF_FFFF);
    md_go(5'd7, 5'd8, 2'b10); md_wait();
    hilo_chk("div_ovf", 32'h0, 32'h8000_0000); chk("div_ovf_dz", 4, 32'h0);

    wreg(5'd7, 32'h1234_5678);
    md_go(5'd7, 5'd0, 2'b11); md_wait();
    chk("divu0_dz", 4, 32'h1);
    hilo_chk("divu0", 32'h1234_5678, 32'hFFFF_FFFF);
    md_go(5'd7, 5'd0, 2'b01);
    chk("dz_cleared", 4, 32'h0);
    md_wait();
    hilo_chk("multu0", 32'h0, 32'h0);

    // MTHI/MTLO
    wreg(5'd9, 32'h0000_CAFE);
    s_addr = 5'd9; tick();
    hilo_wr = 2'b10; tick(); hilo_wr = 2'b01; tick(); hilo_wr = 2'b00;
    hilo_chk("mthilo", 32'h0000_CAFE, 32'h0000_CAFE);

    // Same-cycle write/read of R4
    wreg(5'd4, 32'h55);
    dy = 32'h1234; tick();
    d_en = 1'b1; da_sel = 2'b00; d_addr = 5'd4; y_sel = 3'd3; s_sel = 1'b0; s_addr = 5'd4;
    fs = 5'h00; tick();
    d_en = 1'b0; tick(); y_sel = 3'd2;
`ifdef DP_BYPASS_EN
    byp_exp = 32'h1234;
`else
    byp_exp = 32'h55;
`endif
    chk("bypass_rs", 0, byp_exp);
    alu(5'd4, 5'd0, 5'h00, 5'd0); chk("r4_read", 0, 32'h1234);
    wreg(5'd0, 32'hABCD);
    alu(5'd0, 5'd0, 5'h00, 5'd0);
    chk("r0_read", 0, 32'h0); chk("r0_flags", 2, 32'b0001);

    // RA destination select
    dy = 32'h77; tick();
    d_en = 1'b1; da_sel = 2'b10; y_sel = 3'd3; tick(); d_en = 1'b0; da_sel = 2'b00;
    alu(5'd31, 5'd0, 5'h00, 5'd0); chk("ra_read", 0, 32'h77);

    // Output muxes
    d_out_sel = 2'b10; flags_in = 4'hA; chk("dout_flags", 1, 32'hA);
    pc_in = 32'h400; tick();
    d_out_sel = 2'b01; chk("dout_pc", 1, 32'h400);
    y_sel = 3'd4; chk("y_pc", 0, 32'h400); tick();
    y_sel = 3'd5; chk("y_sel5", 0, 32'h0);
    t_sel = 1'b1; dt = 32'h5A5A; tick();
    d_out_sel = 2'b00; chk("dout_rt", 1, 32'h5A5A); tick();
    d_out_sel = 2'b11; chk("dout_rt3", 1, 32'h5A5A); tick();
    t_sel = 1'b0;

    // Reset in the middle of a MULT
    wreg(5'd7, 32'hFFFF_FFFD); wreg(5'd8, 32'd7);
    md_go(5'd7, 5'd8, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0; void'(md_q.pop_back());
    y_sel = 3'd0;
    chk("mrst_busy", 3, 32'h0); chk("mrst_hi", 0, 32'h0); chk("mrst_flags", 2, 32'h0);
    tick();
    y_sel = 3'd1; chk("mrst_lo", 0, 32'h0); tick();
    reset = 1'b1; y_sel = 3'd0; chk("mrst_hi_after", 0, 32'h0);
    alu(5'd7, 5'd0, 5'h00, 5'd0); chk("mrst_r7", 0, 32'h0);
    for (int i = 0; i < 40; i++) tick();

    tick(); tick();
    checks++;
    if (exp_q.size() + md_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size() + md_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
